// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - operand-fetch / write-back controller for the 4-bit ALU op units
//
// Purpose:
//   Holds a small register file. For each accepted operation it:
//     - fetches two registered operands onto Rd1/Rd2,
//     - raises exactly one unit enable for one cycle,
//     - captures the OR-combined unit result,
//     - writes that result back to the destination register.
//   This block is the initiator of the en/Rd1/Rd2/result interface; the op units respond.
//
// Optional feature (macro SEQ_PIPE_EN):
//   When defined, a start seen in WB chains directly into FETCH (3 cycles per op).
//   When undefined, WB always returns to IDLE (4 cycles per op).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request one operation (ignored while busy)
//   op_sel    in   00 NOT, 01 AND, 10 OR, 11 ADD; selects the enable bit
//   rs1, rs2  in   source register addresses
//   rd        in   destination register address
//   ld_we     in   external register load strobe (honoured in IDLE only)
//   ld_addr   in   load address
//   ld_data   in   load data
//   Rd1, Rd2  out  registered operands to the ALU units
//   en_op     out  one-hot unit enable, valid in EXEC only
//   result    in   OR of all unit outputs
//   busy      out  high whenever the sequencer is not in IDLE
//   done      out  one-cycle pulse after write-back
//   dbg_addr  in   debug read address
//   dbg_data  out  combinational read of the register file

module alu_operand_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2,
  parameter int NOPS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_sel,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] Rd1,
  output logic [DATA_W-1:0] Rd2,
  output logic [NOPS-1:0]   en_op,
  input  logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef SEQ_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] regs [NREG];

  // Operation fields captured at acceptance; the live inputs are never used
  // after that, so they may change freely during the operation.
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] res_q;

  logic accept;
  logic load_ok;

  // A new operation is taken in IDLE, or in WB when chaining is built in.
  assign accept  = start && ((state == IDLE) || (PIPE_EN && (state == WB)));
  assign load_ok = ld_we && (state == IDLE);

  assign busy     = (state != IDLE);
  assign dbg_data = regs[dbg_addr];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FETCH;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = accept ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- latched fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= op_sel;
      rs1_q <= rs1;
      rs2_q <= rs2;
      rd_q  <= rd;
    end
  end

  // ---------------------------------------------------------------- operand fetch / enable
  // Rd1/Rd2 only move in FETCH. en_op is loaded on the FETCH->EXEC edge and
  // cleared on the next edge, so it is high for exactly the EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Rd1   <= '0;
      Rd2   <= '0;
      en_op <= '0;
    end else begin
      if (state == FETCH) begin
        Rd1   <= regs[rs1_q];
        Rd2   <= regs[rs2_q];
        en_op <= NOPS'(1) << op_q;
      end else begin
        en_op <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- result capture
  // With no enable raised the result bus carries nothing meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if ((state == EXEC) && (en_op != '0)) begin
      res_q <= result;
    end
  end

  // ---------------------------------------------------------------- done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == WB);
    end
  end

  // ---------------------------------------------------------------- register file
  // External loads only happen in IDLE and write-back only in WB, so the two
  // write ports never collide. A load on the accepting edge lands before the
  // following FETCH reads it; likewise a chained FETCH sees the WB write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (load_ok) begin
        regs[ld_addr] <= ld_data;
      end
      if (state == WB) begin
        regs[rd_q] <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed self-checking bench for alu_operand_sequencer

module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op_sel;
  logic [1:0] rs1, rs2, rd;
  logic       ld_we;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] Rd1, Rd2;
  logic [3:0] en_op;
  logic [3:0] result;
  logic       busy, done;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .Rd1(Rd1), .Rd2(Rd2), .en_op(en_op), .result(result),
    .busy(busy), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Responder model: each enabled unit drives its function, idle units drive 0.
  assign result = (en_op[0] ? ~Rd1       : 4'h0) |
                  (en_op[1] ? (Rd1 & Rd2) : 4'h0) |
                  (en_op[2] ? (Rd1 | Rd2) : 4'h0) |
                  (en_op[3] ? (Rd1 + Rd2) : 4'h0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [3:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  // Issue one op, then watch six edges for enable cycles and done pulses.
  task automatic do_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, output int en_cyc, output logic [3:0] en_val,
                       output int done_cnt);
    en_cyc = 0; en_val = 4'h0; done_cnt = 0;
    start = 1'b1; op_sel = op; rs1 = a; rs2 = b; rd = d;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (en_op != 4'h0) begin en_cyc++; en_val = en_op; end
      if (done) done_cnt++;
    end
  endtask

  logic [3:0] v;
  int         ec, dc, second_edge, total_exp;
  logic [3:0] ev;

  initial begin
    rst = 1'b1; start = 1'b0; op_sel = 2'd0; rs1 = 2'd0; rs2 = 2'd0; rd = 2'd0;
    ld_we = 1'b0; ld_addr = 2'd0; ld_data = 4'h0; dbg_addr = 2'd0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_en", en_op, 0);
    check("rst_done", done, 0);
    check("rst_rd1", Rd1, 0);
    rst = 1'b0;
    tick();

    // 1: reset during EXEC of NOT R1 -> R2
    load(2'd1, 4'b1010);
    load(2'd3, 4'b0111);
    start = 1'b1; op_sel = 2'd0; rs1 = 2'd1; rs2 = 2'd0; rd = 2'd2;
    tick(); start = 1'b0;           // E0
    tick();                         // E1: now in EXEC
    check("t1_exec_en", en_op, 4'b0001);
    check("t1_exec_rd1", Rd1, 4'b1010);
    rst = 1'b1;
    #1;
    check("t1_rst_rd1", Rd1, 0);
    check("t1_rst_en", en_op, 0);
    check("t1_rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      check("t1_rst_reg", v, 0);
    end
    tick();
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dc++;
    end
    check("t1_no_done", dc, 0);

    // 2: NOT with cycle-by-cycle view
    load(2'd1, 4'b1010);
    start = 1'b1; op_sel = 2'd0; rs1 = 2'd1; rs2 = 2'd0; rd = 2'd2;
    tick(); start = 1'b0;           // E0
    check("t2_e0_busy", busy, 1);
    check("t2_e0_en", en_op, 0);
    tick();                         // E1
    check("t2_e1_rd1", Rd1, 4'b1010);
    check("t2_e1_en", en_op, 4'b0001);
    tick();                         // E2
    check("t2_e2_en", en_op, 0);
    check("t2_e2_done", done, 0);
    tick();                         // E3
    check("t2_e3_done", done, 1);
    check("t2_e3_busy", busy, 0);
    rd_reg(2'd2, v);
    check("t2_r2", v, 4'b0101);
    tick();                         // E4
    check("t2_e4_done", done, 0);
    check("t2_rd1_hold", Rd1, 4'b1010);

    // 3: ADD wraps to 4 bits
    load(2'd0, 4'b1111);
    load(2'd1, 4'b0001);
    do_op(2'd3, 2'd0, 2'd1, 2'd3, ec, ev, dc);
    check("t3_en_val", ev, 4'b1000);
    check("t3_en_cyc", ec, 1);
    check("t3_done", dc, 1);
    rd_reg(2'd3, v); check("t3_r3", v, 4'b0000);
    rd_reg(2'd0, v); check("t3_r0", v, 4'b1111);
    rd_reg(2'd1, v); check("t3_r1", v, 4'b0001);

    // 4a: start and load during EXEC are ignored
    start = 1'b1; op_sel = 2'd0; rs1 = 2'd1; rs2 = 2'd0; rd = 2'd2;
    tick(); start = 1'b0;           // E0
    tick();                         // E1: EXEC
    start = 1'b1; op_sel = 2'd3; rs1 = 2'd0; rs2 = 2'd0; rd = 2'd1;
    ld_we = 1'b1; ld_addr = 2'd1; ld_data = 4'b0110;
    tick();                         // E2
    start = 1'b0; ld_we = 1'b0;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dc++;
    end
    check("t4_done_cnt", dc, 1);
    check("t4_idle", busy, 0);
    rd_reg(2'd1, v); check("t4_r1", v, 4'b0001);
    rd_reg(2'd2, v); check("t4_r2", v, 4'b1110);

    // 4b: load and start on the same IDLE edge
    ld_we = 1'b1; ld_addr = 2'd1; ld_data = 4'b0110;
    do_op(2'd0, 2'd1, 2'd0, 2'd2, ec, ev, dc);
    ld_we = 1'b0;
    check("t4b_done", dc, 1);
    rd_reg(2'd1, v); check("t4b_r1", v, 4'b0110);
    rd_reg(2'd2, v); check("t4b_r2", v, 4'b1001);

    // 5: fully aliased operands
    load(2'd2, 4'b0011);
    do_op(2'd1, 2'd2, 2'd2, 2'd2, ec, ev, dc);
    check("t5_and_done", dc, 1);
    check("t5_and_en", ev, 4'b0010);
    rd_reg(2'd2, v); check("t5_and_r2", v, 4'b0011);
    do_op(2'd2, 2'd2, 2'd2, 2'd2, ec, ev, dc);
    check("t5_or_done", dc, 1);
    check("t5_or_en", ev, 4'b0100);
    rd_reg(2'd2, v); check("t5_or_r2", v, 4'b0011);

    // 6: start held high across two dependent NOTs
    load(2'd1, 4'b1100);
    start = 1'b1; op_sel = 2'd0; rs1 = 2'd1; rs2 = 2'd0; rd = 2'd2;
    tick();                         // E0
    rs1 = 2'd2; rd = 2'd3;
    dc = 0; second_edge = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) begin
`ifdef SEQ_PIPE_EN
        check("t6_busy_chain", busy, 1);
`else
        check("t6_busy_chain", busy, 0);
`endif
      end
      if (done) begin
        dc++;
        if (dc == 2 && second_edge == 0) second_edge = i;
      end
      if (i == 4) start = 1'b0;
    end
`ifdef SEQ_PIPE_EN
    total_exp = 7;
`else
    total_exp = 8;
`endif
    check("t6_done_cnt", dc, 2);
    check("t6_total_cycles", second_edge + 1, total_exp);
    rd_reg(2'd2, v); check("t6_r2", v, 4'b0011);
    rd_reg(2'd3, v); check("t6_r3", v, 4'b1100);
    check("t6_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
